// File: rtl/onedconv_buffer_bank.sv
// Per-lane ifmap/weight shift-register bank feeding a 1-D convolution array.
// Loads under external enables, or streams under a skewed internal sequencer.
module onedconv_buffer_bank #(
    parameter int DW        = 16,
    parameter int DIM       = 16,
    parameter int MAX_DEPTH = 32,
    parameter int LW        = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clr,
    input  logic                             mode,
    input  logic [$clog2(MAX_DEPTH+1)-1:0]   cfg_depth,
    input  logic [DIM-1:0]                   ld_en_ifmap,
    input  logic [DIM-1:0]                   ld_en_weight,
    input  logic [DW-1:0]                    ifmap_serial_in,
    input  logic [DIM*DW-1:0]                weight_brams_in,
    input  logic                             zero_ins,
    input  logic                             start,
    input  logic [LW-1:0]                    run_len,
    output logic                             busy,
    output logic                             done,
    output logic [DIM-1:0]                   lane_valid,
    output logic [DIM*DW-1:0]                ifmap_flat,
    output logic [DIM*DW-1:0]                weight_flat
);

    localparam int CW = $clog2(MAX_DEPTH + 1);
    localparam int AW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
    localparam int TW = LW + $clog2(DIM + 1) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nx;
    logic [TW-1:0] t, t_nx;
    logic [LW-1:0] len, len_nx;
    logic [TW-1:0] last;
    logic [DIM-1:0] run_en, sh_i, sh_w;
    logic [CW-1:0] d;
    logic [AW-1:0] tap;
    logic [DW-1:0] ifm_in;

    assign last   = TW'(len) + TW'(DIM) - TW'(2);
    assign ifm_in = zero_ins ? '0 : ifmap_serial_in;

    always_comb begin
        state_nx = state;
        t_nx     = t;
        len_nx   = len;
        unique case (state)
            IDLE: if (mode && start) begin
                len_nx   = run_len;
                t_nx     = '0;
                state_nx = (run_len != '0) ? RUN : DONE;
            end
            RUN: if (!mode) begin
                state_nx = IDLE;
            end else begin
                t_nx = t + TW'(1);
                if (t == last) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (clr) begin
            state_nx = IDLE;
            t_nx     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            t     <= '0;
            len   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            t     <= t_nx;
            len   <= len_nx;
            busy  <= (state_nx == RUN);
            done  <= (state_nx == DONE);
        end
    end

    // Lane i is active for L cycles starting at t = i.
    always_comb begin
        run_en = '0;
        for (int i = 0; i < DIM; i++) begin
            run_en[i] = (state == RUN) && (t >= TW'(i))
                        && (t < TW'(i) + TW'(len));
        end
        sh_i = mode ? run_en : ld_en_ifmap;
        sh_w = mode ? run_en : ld_en_weight;
    end

    always_comb begin
        if (cfg_depth == '0)
            d = CW'(1);
        else if (cfg_depth > CW'(MAX_DEPTH))
            d = CW'(MAX_DEPTH);
        else
            d = cfg_depth;
        tap = AW'(d - CW'(1));
    end

    for (genvar g = 0; g < DIM; g++) begin : g_lane
        logic [DW-1:0] ifm [MAX_DEPTH];
        logic [DW-1:0] wgt [MAX_DEPTH];
        logic [CW-1:0] cnt_i, cnt_w;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int k = 0; k < MAX_DEPTH; k++) begin
                    ifm[k] <= '0;
                    wgt[k] <= '0;
                end
                cnt_i <= '0;
                cnt_w <= '0;
            end else if (clr) begin
                for (int k = 0; k < MAX_DEPTH; k++) begin
                    ifm[k] <= '0;
                    wgt[k] <= '0;
                end
                cnt_i <= '0;
                cnt_w <= '0;
            end else begin
                if (sh_i[g]) begin
                    ifm[0] <= ifm_in;
                    for (int k = 1; k < MAX_DEPTH; k++) ifm[k] <= ifm[k-1];
                    if (cnt_i != CW'(MAX_DEPTH)) cnt_i <= cnt_i + CW'(1);
                end
                if (sh_w[g]) begin
                    wgt[0] <= weight_brams_in[DW*g +: DW];
                    for (int k = 1; k < MAX_DEPTH; k++) wgt[k] <= wgt[k-1];
                    if (cnt_w != CW'(MAX_DEPTH)) cnt_w <= cnt_w + CW'(1);
                end
            end
        end

        assign ifmap_flat[DW*g +: DW]  = ifm[tap];
        assign weight_flat[DW*g +: DW] = wgt[tap];
        assign lane_valid[g] = (cnt_i >= d) && (cnt_w >= d);
    end

endmodule

// File: tb/tb_onedconv_buffer_bank.sv
// Bench for onedconv_buffer_bank: per-cycle reference model plus
// hand-computed literal checks of load, zero-insert, run, abort and clamp.
module tb_onedconv_buffer_bank;

    localparam int DW  = 16;
    localparam int DIM = 4;
    localparam int MD  = 8;
    localparam int LW  = 8;
    localparam int CW  = $clog2(MD + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, clr, mode, zero_ins, start;
    logic [CW-1:0]     cfg_depth;
    logic [DIM-1:0]    ld_en_ifmap, ld_en_weight;
    logic [DW-1:0]     ifmap_serial_in;
    logic [DIM*DW-1:0] weight_brams_in;
    logic [LW-1:0]     run_len;
    logic              busy, done;
    logic [DIM-1:0]    lane_valid;
    logic [DIM*DW-1:0] ifmap_flat, weight_flat;

    onedconv_buffer_bank #(.DW(DW), .DIM(DIM), .MAX_DEPTH(MD), .LW(LW)) dut (
        .clk(clk), .rst(rst), .clr(clr), .mode(mode),
        .cfg_depth(cfg_depth),
        .ld_en_ifmap(ld_en_ifmap), .ld_en_weight(ld_en_weight),
        .ifmap_serial_in(ifmap_serial_in),
        .weight_brams_in(weight_brams_in),
        .zero_ins(zero_ins), .start(start), .run_len(run_len),
        .busy(busy), .done(done), .lane_valid(lane_valid),
        .ifmap_flat(ifmap_flat), .weight_flat(weight_flat)
    );

    int vecs = 0;
    int errs = 0;

    task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got %h want %h", nm, got, exp);
        end
    endtask

    // Reference model: register contents as plain arrays, sequence as
    // "cycles since start" against the run length.
    logic [DW-1:0] mi [DIM][MD];
    logic [DW-1:0] mw [DIM][MD];
    int ci [DIM];
    int cw [DIM];
    int run_k = -1;
    int run_L = 0;

    function automatic int eff_depth(int c);
        if (c == 0) return 1;
        if (c > MD) return MD;
        return c;
    endfunction

    function automatic int run_total();
        return (run_L == 0) ? 0 : run_L + DIM - 1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DIM; i++) begin
            for (int k = 0; k < MD; k++) begin
                mi[i][k] = '0;
                mw[i][k] = '0;
            end
            ci[i] = 0;
            cw[i] = 0;
        end
        run_k = -1;
    endtask

    always @(posedge clk) begin
        logic [DIM-1:0] ei, ew;
        logic [63:0] e_if, e_w;
        logic [DIM-1:0] e_v;
        int dd;
        if (!rst || clr) begin
            model_clear();
        end else begin
            ei = '0;
            ew = '0;
            if (!mode) begin
                ei = ld_en_ifmap;
                ew = ld_en_weight;
            end else if (run_k >= 0) begin
                for (int i = 0; i < DIM; i++)
                    if (i <= run_k && run_k < i + run_L) begin
                        ei[i] = 1'b1;
                        ew[i] = 1'b1;
                    end
            end
            for (int i = 0; i < DIM; i++) begin
                if (ei[i]) begin
                    for (int k = MD - 1; k > 0; k--) mi[i][k] = mi[i][k-1];
                    mi[i][0] = zero_ins ? '0 : ifmap_serial_in;
                    if (ci[i] < MD) ci[i]++;
                end
                if (ew[i]) begin
                    for (int k = MD - 1; k > 0; k--) mw[i][k] = mw[i][k-1];
                    mw[i][0] = weight_brams_in[DW*i +: DW];
                    if (cw[i] < MD) cw[i]++;
                end
            end
            if (run_k >= 0) begin
                if (!mode || run_k == run_total()) run_k = -1;
                else run_k++;
            end else if (mode && start) begin
                run_k = 0;
                run_L = int'(run_len);
            end
        end
        #1;
        dd = eff_depth(int'(cfg_depth));
        for (int i = 0; i < DIM; i++) begin
            e_if[DW*i +: DW] = mi[i][dd-1];
            e_w[DW*i +: DW]  = mw[i][dd-1];
            e_v[i] = (ci[i] >= dd) && (cw[i] >= dd);
        end
        chk("m_ifmap", ifmap_flat, e_if);
        chk("m_weight", weight_flat, e_w);
        chk("m_valid", 64'(lane_valid), 64'(e_v));
        chk("m_busy", 64'(busy),
            64'(run_k >= 0 && run_L > 0 && run_k < run_L + DIM - 1));
        chk("m_done", 64'(done), 64'(run_k >= 0 && run_k == run_total()));
    end

    task automatic tick(int n = 1);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; clr = 1'b0; mode = 1'b0; zero_ins = 1'b0; start = 1'b0;
        cfg_depth = 3; ld_en_ifmap = '0; ld_en_weight = '0;
        ifmap_serial_in = '0; weight_brams_in = '0; run_len = '0;
        tick(2);
        chk("rst_ifmap", ifmap_flat, 0);
        chk("rst_valid", 64'(lane_valid), 0);
        chk("rst_busy", 64'(busy), 0);
        rst = 1'b1;
        tick();

        // load phase, depth 3
        ld_en_ifmap = 4'b0001;
        for (int v = 5; v <= 7; v++) begin
            ifmap_serial_in = DW'(v);
            tick();
        end
        ld_en_ifmap = '0;
        chk("ld_tap0", 64'(ifmap_flat[15:0]), 5);
        chk("ld_valid_early", 64'(lane_valid), 0);
        chk("ld_others", 64'(ifmap_flat[63:16]), 0);
        ld_en_weight = 4'b0001;
        for (int v = 0; v < 3; v++) begin
            weight_brams_in = 64'(100 + v);
            tick();
        end
        ld_en_weight = '0;
        chk("ld_valid", 64'(lane_valid), 64'b0001);
        chk("ld_wtap0", 64'(weight_flat[15:0]), 100);

        // zero insertion, depth 2
        cfg_depth = 2;
        ld_en_ifmap = 4'b0010;
        ifmap_serial_in = 9; zero_ins = 1'b0;
        tick();
        ifmap_serial_in = 4; zero_ins = 1'b1;
        tick();
        ld_en_ifmap = '0;
        chk("zi_tap1", 64'(ifmap_flat[31:16]), 9);
        ld_en_ifmap = 4'b0010;
        tick();
        ld_en_ifmap = '0; zero_ins = 1'b0;
        chk("zi_tap1_zero", 64'(ifmap_flat[31:16]), 0);

        // skewed run, L=3
        cfg_depth = 3; mode = 1'b1; run_len = 3;
        weight_brams_in = {16'h0d00, 16'h0c00, 16'h0b00, 16'h0a00};
        ifmap_serial_in = 20; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("run_busy_%0d", c), 64'(busy), 64'(c < 6));
            chk($sformatf("run_done_%0d", c), 64'(done), 64'(c == 6));
            ifmap_serial_in = DW'(21 + c);
            start = (c == 2);
            tick();
        end
        start = 1'b0;
        chk("run_tap0", 64'(ifmap_flat[15:0]), 21);
        chk("run_tap3", 64'(ifmap_flat[63:48]), 24);
        chk("run_wtap0", 64'(weight_flat[15:0]), 64'h0a00);
        chk("run_valid", 64'(lane_valid), 64'hf);

        // zero-length run
        run_len = 0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("zl_done", 64'(done), 1);
        chk("zl_busy", 64'(busy), 0);
        tick();
        chk("zl_done_off", 64'(done), 0);

        // mode drop mid-run
        run_len = 5; start = 1'b1;
        tick();
        start = 1'b0;
        tick(2);
        mode = 1'b0;
        tick();
        chk("drop_busy", 64'(busy), 0);
        tick(8);
        mode = 1'b1;

        // async reset mid-run
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(2);
        rst = 1'b0;
        #1;
        chk("arst_ifmap", ifmap_flat, 0);
        chk("arst_valid", 64'(lane_valid), 0);
        chk("arst_busy", 64'(busy), 0);
        tick();
        rst = 1'b1;
        tick(8);

        // clear mid-run after a refill
        mode = 1'b0; ld_en_ifmap = '1; ld_en_weight = '1;
        ifmap_serial_in = 7; weight_brams_in = {4{16'h0033}};
        tick(3);
        ld_en_ifmap = '0; ld_en_weight = '0;
        mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(2);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_ifmap", ifmap_flat, 0);
        chk("clr_weight", weight_flat, 0);
        chk("clr_valid", 64'(lane_valid), 0);
        chk("clr_busy", 64'(busy), 0);
        tick(8);

        // depth clamp
        mode = 1'b0; cfg_depth = 0;
        ld_en_ifmap = 4'b0100; ld_en_weight = 4'b0100;
        ifmap_serial_in = 33; weight_brams_in = 64'(44) << 32;
        tick();
        ld_en_ifmap = '0; ld_en_weight = '0;
        chk("clamp0_valid", 64'(lane_valid), 64'b0100);
        chk("clamp0_tap2", 64'(ifmap_flat[47:32]), 33);
        chk("clamp0_wtap2", 64'(weight_flat[47:32]), 44);
        cfg_depth = 12;
        ld_en_ifmap = 4'b0100;
        for (int v = 0; v < 8; v++) begin
            ifmap_serial_in = DW'(50 + v);
            tick();
        end
        ld_en_ifmap = '0;
        chk("clampmax_tap2", 64'(ifmap_flat[47:32]), 50);
        chk("clampmax_valid", 64'(lane_valid), 0);
        cfg_depth = 1;
        #1;
        chk("depth1_tap2", 64'(ifmap_flat[47:32]), 57);
        chk("depth1_valid", 64'(lane_valid), 64'b0100);
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
